des_feistel_f: RTL and testbench

- Pipelined DES round function f(R,K) = P(S(E(R) xor K)).
- Sits between the round-key scheduler and the Feistel round register.
- Instantiates the eight existing S-box modules (s1box..s8box, 6-bit in, 4-bit out, [1:n] MSB-first DES numbering) as the substitution layer.
- Adds the E expansion, key mixing, P permutation and valid/ready pipelining around them.

---
 rtl/des_feistel_f_if.sv | 24 ++
 rtl/des_feistel_f.sv | 151 +++++++++++++++
 tb/tb_des_feistel_f.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_feistel_f_if.sv
// Valid/ready bus around the DES round function: R and K in, f(R,K) out.
// DES bit numbering throughout: bit 1 is the MSB.
interface des_feistel_f_if #(
    parameter int BUSY_CNT_W = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:32]           r_in;
    logic [1:48]           k_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:32]           f_out;
    logic [BUSY_CNT_W-1:0] in_flight;

    modport master (
        output in_valid, r_in, k_in, out_ready,
        input  in_ready, out_valid, f_out, in_flight
    );

    modport slave (
        input  in_valid, r_in, k_in, out_ready,
        output in_ready, out_valid, f_out, in_flight
    );
endinterface

// File: rtl/des_feistel_f.sv
// DES round function f(R,K) = P(S(E(R) xor K)) with an optional E/xor register stage
// and a registered output stage, both under no-bubble valid/ready flow control.
module des_sbox_lut #(
    parameter logic [255:0] TBL = '0
) (
    input  logic [1:6] i_b,
    output logic [1:4] o_s
);
    // Row = outer bits {b1,b6}, column = inner bits b2..b5; entry 0 sits in the top nibble.
    logic [5:0]   w_idx;
    logic [255:0] w_sh;

    assign w_idx = {i_b[1], i_b[6], i_b[2:5]};
    assign w_sh  = TBL << {w_idx, 2'b00};
    assign o_s   = w_sh[255:252];
endmodule

module s1box (input logic [1:6] i_b, output logic [1:4] o_s);
    des_sbox_lut #(.TBL(256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D)) u_lut (.i_b(i_b), .o_s(o_s));
endmodule

module s2box (input logic [1:6] i_b, output logic [1:4] o_s);
    des_sbox_lut #(.TBL(256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9)) u_lut (.i_b(i_b), .o_s(o_s));
endmodule

module s3box (input logic [1:6] i_b, output logic [1:4] o_s);
    des_sbox_lut #(.TBL(256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C)) u_lut (.i_b(i_b), .o_s(o_s));
endmodule

module s4box (input logic [1:6] i_b, output logic [1:4] o_s);
    des_sbox_lut #(.TBL(256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E)) u_lut (.i_b(i_b), .o_s(o_s));
endmodule

module s5box (input logic [1:6] i_b, output logic [1:4] o_s);
    des_sbox_lut #(.TBL(256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453)) u_lut (.i_b(i_b), .o_s(o_s));
endmodule

module s6box (input logic [1:6] i_b, output logic [1:4] o_s);
    des_sbox_lut #(.TBL(256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D)) u_lut (.i_b(i_b), .o_s(o_s));
endmodule

module s7box (input logic [1:6] i_b, output logic [1:4] o_s);
    des_sbox_lut #(.TBL(256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C)) u_lut (.i_b(i_b), .o_s(o_s));
endmodule

module s8box (input logic [1:6] i_b, output logic [1:4] o_s);
    des_sbox_lut #(.TBL(256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B)) u_lut (.i_b(i_b), .o_s(o_s));
endmodule

module des_feistel_f #(
    parameter int REG_IN     = 1,
    parameter int BUSY_CNT_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    des_feistel_f_if.slave bus
);
    logic [1:32]           w_r;
    logic [1:48]           w_x0;
    logic [1:48]           w_x1;
    logic                  w_v1;
    logic                  w_s2_ready;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic [1:32]           w_s;
    logic [1:32]           w_p;
    logic                  r_v2;
    logic [1:32]           r_f;
    logic [BUSY_CNT_W-1:0] r_cnt;

    assign w_r  = bus.r_in;
    assign w_x0 = {w_r[32], w_r[1:5], w_r[4:9], w_r[8:13], w_r[12:17], w_r[16:21],
                   w_r[20:25], w_r[24:29], w_r[28:32], w_r[1]} ^ bus.k_in;

    assign w_s2_ready = !r_v2 || bus.out_ready;

    generate
        if (REG_IN != 0) begin : g_stage1
            logic        r_v1;
            logic [1:48] r_x1;
            logic        w_s1_ready;

            assign w_s1_ready = !r_v1 || w_s2_ready;

            // When the stage may move, it either refills from the input or empties.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v1 <= 1'b0;
                    r_x1 <= '0;
                end else if (w_s1_ready) begin
                    r_v1 <= bus.in_valid;
                    if (bus.in_valid) begin
                        r_x1 <= w_x0;
                    end
                end
            end

            assign bus.in_ready = w_s1_ready;
            assign w_v1         = r_v1;
            assign w_x1         = r_x1;
        end else begin : g_bypass
            assign bus.in_ready = w_s2_ready;
            assign w_v1         = bus.in_valid;
            assign w_x1         = w_x0;
        end
    endgenerate

    s1box u_s1 (.i_b(w_x1[1:6]),   .o_s(w_s[1:4]));
    s2box u_s2 (.i_b(w_x1[7:12]),  .o_s(w_s[5:8]));
    s3box u_s3 (.i_b(w_x1[13:18]), .o_s(w_s[9:12]));
    s4box u_s4 (.i_b(w_x1[19:24]), .o_s(w_s[13:16]));
    s5box u_s5 (.i_b(w_x1[25:30]), .o_s(w_s[17:20]));
    s6box u_s6 (.i_b(w_x1[31:36]), .o_s(w_s[21:24]));
    s7box u_s7 (.i_b(w_x1[37:42]), .o_s(w_s[25:28]));
    s8box u_s8 (.i_b(w_x1[43:48]), .o_s(w_s[29:32]));

    assign w_p = {w_s[16], w_s[7],  w_s[20], w_s[21], w_s[29], w_s[12], w_s[28], w_s[17],
                  w_s[1],  w_s[15], w_s[23], w_s[26], w_s[5],  w_s[18], w_s[31], w_s[10],
                  w_s[2],  w_s[8],  w_s[24], w_s[14], w_s[32], w_s[27], w_s[3],  w_s[9],
                  w_s[19], w_s[13], w_s[30], w_s[6],  w_s[22], w_s[11], w_s[4],  w_s[25]};

    // f_out only loads with a new item, so it keeps the last result while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_f  <= '0;
        end else if (w_s2_ready) begin
            r_v2 <= w_v1;
            if (w_v1) begin
                r_f <= w_p;
            end
        end
    end

    assign w_in_xfer  = bus.in_valid && bus.in_ready;
    assign w_out_xfer = r_v2 && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_cnt <= r_cnt + BUSY_CNT_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_cnt <= r_cnt - BUSY_CNT_W'(1);
        end
    end

    assign bus.out_valid = r_v2;
    assign bus.f_out     = r_f;
    assign bus.in_flight = r_cnt;
endmodule

// File: tb/tb_des_feistel_f.sv
// Bench for des_feistel_f: drives a REG_IN=1 and a REG_IN=0 instance with identical stimulus,
// each tracked by its own elastic-buffer reference model built from the FIPS tables.
module tb_des_feistel_f;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        t_in_valid = 1'b0;
    logic        t_out_ready = 1'b0;
    logic [31:0] t_r = '0;
    logic [47:0] t_k = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                     16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    // Per-DUT model: index 0 = REG_IN=0 (capacity 1, latency 1), index 1 = REG_IN=1 (capacity 2, latency 2).
    logic [31:0] m_data [2][2];
    int          m_age  [2][2];
    int          m_cnt  [2];
    int          m_acc  [2];
    logic [31:0] m_last [2];
    logic        e_rdy [2];
    logic        e_ov  [2];
    logic [31:0] e_f   [2];
    logic [1:0]  e_cnt [2];
    logic        a_rdy [2];
    logic        a_ov  [2];
    logic [31:0] a_f   [2];
    logic [1:0]  a_cnt [2];

    always #5 clk = ~clk;

    des_feistel_f_if #(.BUSY_CNT_W(2)) bus1 ();
    des_feistel_f_if #(.BUSY_CNT_W(2)) bus0 ();

    assign bus1.in_valid  = t_in_valid;
    assign bus1.r_in      = t_r;
    assign bus1.k_in      = t_k;
    assign bus1.out_ready = t_out_ready;
    assign bus0.in_valid  = t_in_valid;
    assign bus0.r_in      = t_r;
    assign bus0.k_in      = t_k;
    assign bus0.out_ready = t_out_ready;

    des_feistel_f #(.REG_IN(1), .BUSY_CNT_W(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    des_feistel_f #(.REG_IN(0), .BUSY_CNT_W(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] f;
        logic [5:0]  six;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            s[31-4*b -: 4] = 4'(SB[b][int'({six[5], six[0], six[4:1]})]);
        end
        for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
        return f;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_acc[d]  = 0;
            m_last[d] = '0;
            for (int j = 0; j < 2; j++) begin
                m_data[d][j] = '0;
                m_age[d][j]  = 0;
            end
        end
    endtask

    // Settle the inputs, capture the DUT outputs and the model's expectation for this cycle.
    task automatic observe_predict();
        #1;
        a_rdy[1] = bus1.in_ready;  a_ov[1] = bus1.out_valid;  a_f[1] = bus1.f_out;  a_cnt[1] = bus1.in_flight;
        a_rdy[0] = bus0.in_ready;  a_ov[0] = bus0.out_valid;  a_f[0] = bus0.f_out;  a_cnt[0] = bus0.in_flight;
        for (int d = 0; d < 2; d++) begin
            e_rdy[d] = (m_cnt[d] < d + 1) || t_out_ready;
            e_ov[d]  = (m_cnt[d] > 0) && (m_age[d][0] >= d + 1);
            e_f[d]   = e_ov[d] ? m_data[d][0] : m_last[d];
            e_cnt[d] = 2'(m_cnt[d]);
        end
    endtask

    task automatic advance();
        logic ox;
        logic ix;
        for (int d = 0; d < 2; d++) begin
            ox = e_ov[d] && t_out_ready;
            ix = t_in_valid && e_rdy[d];
            if (ox) begin
                m_last[d]    = m_data[d][0];
                m_data[d][0] = m_data[d][1];
                m_age[d][0]  = m_age[d][1];
                m_cnt[d]--;
            end
            for (int j = 0; j < m_cnt[d]; j++) m_age[d][j]++;
            if (ix && m_cnt[d] < 2) begin
                m_data[d][m_cnt[d]] = ref_f(t_r, t_k);
                m_age[d][m_cnt[d]]  = 1;
                m_cnt[d]++;
                m_acc[d]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        observe_predict();
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (a_ov[d] !== 1'b0) begin n_fail++; $display("FAIL reset out_valid dut%0d: got %b want 0", d, a_ov[d]); end
            n_tests++; if (a_f[d] !== 32'h0) begin n_fail++; $display("FAIL reset f_out dut%0d: got %h want 00000000", d, a_f[d]); end
            n_tests++; if (a_cnt[d] !== 2'd0) begin n_fail++; $display("FAIL reset in_flight dut%0d: got %0d want 0", d, a_cnt[d]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        observe_predict();
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (a_rdy[d] !== 1'b1) begin n_fail++; $display("FAIL reset in_ready dut%0d: got %b want 1", d, a_rdy[d]); end
        end
        @(negedge clk);
    endtask

    task automatic test_known(input logic [31:0] r, input logic [47:0] k, input logic [47:0] want_x1,
                              input logic [31:0] want_s, input logic [31:0] want_f, input string name);
        t_in_valid = 1'b1; t_r = r; t_k = k; t_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            observe_predict();
            for (int d = 0; d < 2; d++) begin
                n_tests++; if (a_rdy[d] !== e_rdy[d]) begin n_fail++; $display("FAIL %s in_ready dut%0d c%0d: got %b want %b", name, d, c, a_rdy[d], e_rdy[d]); end
                n_tests++; if (a_ov[d] !== e_ov[d]) begin n_fail++; $display("FAIL %s out_valid dut%0d c%0d: got %b want %b", name, d, c, a_ov[d], e_ov[d]); end
                n_tests++; if (a_f[d] !== e_f[d]) begin n_fail++; $display("FAIL %s f_out dut%0d c%0d: got %h want %h", name, d, c, a_f[d], e_f[d]); end
                n_tests++; if (a_cnt[d] !== e_cnt[d]) begin n_fail++; $display("FAIL %s in_flight dut%0d c%0d: got %0d want %0d", name, d, c, a_cnt[d], e_cnt[d]); end
            end
            if (c == 1) begin
                n_tests++; if (a_ov[0] !== 1'b1 || a_f[0] !== want_f) begin n_fail++; $display("FAIL %s lat1 result: got v=%b %h want v=1 %h", name, a_ov[0], a_f[0], want_f); end
                n_tests++; if (a_ov[1] !== 1'b0) begin n_fail++; $display("FAIL %s lat2 early valid: got %b want 0", name, a_ov[1]); end
                n_tests++; if (u_dut1.g_stage1.r_x1 !== want_x1) begin n_fail++; $display("FAIL %s x1: got %h want %h", name, u_dut1.g_stage1.r_x1, want_x1); end
                n_tests++; if (u_dut1.w_s !== want_s) begin n_fail++; $display("FAIL %s s_layer: got %h want %h", name, u_dut1.w_s, want_s); end
            end
            if (c == 2) begin
                n_tests++; if (a_ov[1] !== 1'b1 || a_f[1] !== want_f) begin n_fail++; $display("FAIL %s lat2 result: got v=%b %h want v=1 %h", name, a_ov[1], a_f[1], want_f); end
            end
            advance();
            t_in_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int del1 = 0;
        t_out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            t_in_valid = (c < 16);
            t_r = $urandom; t_k = {16'($urandom), $urandom};
            observe_predict();
            for (int d = 0; d < 2; d++) begin
                n_tests++; if (a_rdy[d] !== e_rdy[d]) begin n_fail++; $display("FAIL b2b in_ready dut%0d c%0d: got %b want %b", d, c, a_rdy[d], e_rdy[d]); end
                n_tests++; if (a_ov[d] !== e_ov[d]) begin n_fail++; $display("FAIL b2b out_valid dut%0d c%0d: got %b want %b", d, c, a_ov[d], e_ov[d]); end
                n_tests++; if (a_f[d] !== e_f[d]) begin n_fail++; $display("FAIL b2b f_out dut%0d c%0d: got %h want %h", d, c, a_f[d], e_f[d]); end
                n_tests++; if (a_cnt[d] !== e_cnt[d]) begin n_fail++; $display("FAIL b2b in_flight dut%0d c%0d: got %0d want %0d", d, c, a_cnt[d], e_cnt[d]); end
            end
            if (c >= 2 && c < 16) begin
                n_tests++; if (a_cnt[1] !== 2'd2 || a_rdy[1] !== 1'b1) begin n_fail++; $display("FAIL b2b steady c%0d: got cnt=%0d rdy=%b want cnt=2 rdy=1", c, a_cnt[1], a_rdy[1]); end
            end
            if (a_ov[1] === 1'b1) del1++;
            advance();
        end
        n_tests++; if (del1 !== 16) begin n_fail++; $display("FAIL b2b delivered count: got %0d want 16", del1); end
    endtask

    task automatic test_backpressure();
        int del1 = 0;
        t_out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            t_in_valid = (c < 5);
            t_out_ready = (c >= 5);
            t_r = $urandom; t_k = {16'($urandom), $urandom};
            observe_predict();
            for (int d = 0; d < 2; d++) begin
                n_tests++; if (a_rdy[d] !== e_rdy[d]) begin n_fail++; $display("FAIL bp in_ready dut%0d c%0d: got %b want %b", d, c, a_rdy[d], e_rdy[d]); end
                n_tests++; if (a_ov[d] !== e_ov[d]) begin n_fail++; $display("FAIL bp out_valid dut%0d c%0d: got %b want %b", d, c, a_ov[d], e_ov[d]); end
                n_tests++; if (a_f[d] !== e_f[d]) begin n_fail++; $display("FAIL bp f_out dut%0d c%0d: got %h want %h", d, c, a_f[d], e_f[d]); end
                n_tests++; if (a_cnt[d] !== e_cnt[d]) begin n_fail++; $display("FAIL bp in_flight dut%0d c%0d: got %0d want %0d", d, c, a_cnt[d], e_cnt[d]); end
            end
            if (c == 4) begin
                n_tests++; if (a_rdy[1] !== 1'b0 || a_cnt[1] !== 2'd2) begin n_fail++; $display("FAIL bp full: got rdy=%b cnt=%0d want rdy=0 cnt=2", a_rdy[1], a_cnt[1]); end
            end
            if (a_ov[1] === 1'b1 && t_out_ready) del1++;
            advance();
        end
        n_tests++; if (del1 !== 2) begin n_fail++; $display("FAIL bp delivered count: got %0d want 2", del1); end
    endtask

    task automatic test_random_handshake();
        int cyc = 0;
        int start = m_acc[1];
        while (m_acc[1] - start < 1000 && cyc < 6000) begin
            t_in_valid  = 1'($urandom_range(0, 1));
            t_out_ready = 1'($urandom_range(0, 1));
            t_r = $urandom; t_k = {16'($urandom), $urandom};
            observe_predict();
            for (int d = 0; d < 2; d++) begin
                n_tests++; if (a_rdy[d] !== e_rdy[d]) begin n_fail++; $display("FAIL rnd in_ready dut%0d cyc%0d: got %b want %b", d, cyc, a_rdy[d], e_rdy[d]); end
                n_tests++; if (a_ov[d] !== e_ov[d]) begin n_fail++; $display("FAIL rnd out_valid dut%0d cyc%0d: got %b want %b", d, cyc, a_ov[d], e_ov[d]); end
                n_tests++; if (a_f[d] !== e_f[d]) begin n_fail++; $display("FAIL rnd f_out dut%0d cyc%0d: got %h want %h", d, cyc, a_f[d], e_f[d]); end
                n_tests++; if (a_cnt[d] !== e_cnt[d]) begin n_fail++; $display("FAIL rnd in_flight dut%0d cyc%0d: got %0d want %0d", d, cyc, a_cnt[d], e_cnt[d]); end
            end
            advance();
            cyc++;
        end
        n_tests++; if (m_acc[1] - start < 1000) begin n_fail++; $display("FAIL rnd budget: got %0d items want 1000", m_acc[1] - start); end
        t_in_valid = 1'b0; t_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            observe_predict();
            for (int d = 0; d < 2; d++) begin
                n_tests++; if (a_ov[d] !== e_ov[d]) begin n_fail++; $display("FAIL rnd drain out_valid dut%0d: got %b want %b", d, a_ov[d], e_ov[d]); end
                n_tests++; if (a_f[d] !== e_f[d]) begin n_fail++; $display("FAIL rnd drain f_out dut%0d: got %h want %h", d, a_f[d], e_f[d]); end
                n_tests++; if (a_cnt[d] !== e_cnt[d]) begin n_fail++; $display("FAIL rnd drain in_flight dut%0d: got %0d want %0d", d, a_cnt[d], e_cnt[d]); end
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        t_out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            t_in_valid = 1'b1;
            t_r = $urandom; t_k = {16'($urandom), $urandom};
            observe_predict();
            advance();
        end
        t_in_valid = 1'b0;
        observe_predict();
        n_tests++; if (a_cnt[1] !== 2'd2) begin n_fail++; $display("FAIL arst preload in_flight: got %0d want 2", a_cnt[1]); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (bus1.out_valid !== 1'b0 || bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst out_valid: got %b/%b want 0/0", bus1.out_valid, bus0.out_valid); end
        n_tests++; if (bus1.in_flight !== 2'd0 || bus0.in_flight !== 2'd0) begin n_fail++; $display("FAIL arst in_flight: got %0d/%0d want 0/0", bus1.in_flight, bus0.in_flight); end
        n_tests++; if (bus1.f_out !== 32'h0 || bus0.f_out !== 32'h0) begin n_fail++; $display("FAIL arst f_out: got %h/%h want 0/0", bus1.f_out, bus0.f_out); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        t_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            t_in_valid = (c == 1);
            t_r = $urandom; t_k = {16'($urandom), $urandom};
            observe_predict();
            for (int d = 0; d < 2; d++) begin
                n_tests++; if (a_ov[d] !== e_ov[d]) begin n_fail++; $display("FAIL arst post out_valid dut%0d c%0d: got %b want %b", d, c, a_ov[d], e_ov[d]); end
                n_tests++; if (a_f[d] !== e_f[d]) begin n_fail++; $display("FAIL arst post f_out dut%0d c%0d: got %h want %h", d, c, a_f[d], e_f[d]); end
                n_tests++; if (a_cnt[d] !== e_cnt[d]) begin n_fail++; $display("FAIL arst post in_flight dut%0d c%0d: got %0d want %0d", d, c, a_cnt[d], e_cnt[d]); end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_known(32'hF0AAF0AA, 48'h1B02EFFC7072, 48'h6117BA866527, 32'h5C82B597, 32'h234AA9BB, "kat");
        test_known(32'h0, 48'h0, 48'h0, 32'hEFA72C4D, 32'hD8D8DBBC, "zero");
        test_back_to_back();
        test_backpressure();
        test_random_handshake();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
